// File: rtl/b_resp_gen_if.sv
// Bus bundle between the AW/W acceptance logic, the write-response
// generator and the B-channel interconnect slave port.
interface b_resp_gen_if #(
  parameter int sID_width  = 6,
  parameter int user_width = 1
);
  // AW side
  logic                  aw_push;
  logic [sID_width-1:0]  aw_id;
  logic [user_width-1:0] aw_user;
  logic                  aw_decerr;
  logic                  aw_full;
  // W side
  logic                  wlast_push;
  logic                  w_err;
  logic                  wl_ready;
  // B side
  logic [sID_width-1:0]  BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic [user_width-1:0] BUSER;
  logic                  BREADY;
  // status
  logic                  prot_err;

  modport slave (
    input  aw_push, aw_id, aw_user, aw_decerr, wlast_push, w_err, BREADY,
    output aw_full, wl_ready, BID, BRESP, BVALID, BUSER, prot_err
  );

  modport master (
    output aw_push, aw_id, aw_user, aw_decerr, wlast_push, w_err, BREADY,
    input  aw_full, wl_ready, BID, BRESP, BVALID, BUSER, prot_err
  );
endinterface

// File: rtl/b_resp_gen.sv
// Slave-side write-response generator. Queues {ID, user, decode status}
// of every accepted AW, pairs each accepted WLAST beat with the oldest
// queued AW, and presents the resulting response through a B-channel FIFO.
module b_resp_gen #(
  parameter int sID_width  = 6,
  parameter int user_width = 1,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  b_resp_gen_if.slave   bus
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AEW = sID_width + user_width + 1;
  localparam int unsigned REW = sID_width + user_width + 2;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // DECERR outranks SLVERR; otherwise OKAY.
  function automatic logic [1:0] resp_code(input logic decerr, input logic werr);
    logic [1:0] code;
    if (decerr) begin
      code = 2'b11;
    end else if (werr) begin
      code = 2'b10;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  // AW-ID queue state
  logic [AEW-1:0] aw_mem_q [DEPTH];
  logic [PW-1:0]  aw_wp_q, aw_wp_d;
  logic [PW-1:0]  aw_rp_q, aw_rp_d;
  logic [CW-1:0]  aw_cnt_q, aw_cnt_d;

  // Response FIFO state
  logic [REW-1:0] rs_mem_q [DEPTH];
  logic [PW-1:0]  rs_wp_q, rs_wp_d;
  logic [PW-1:0]  rs_rp_q, rs_rp_d;
  logic [CW-1:0]  rs_cnt_q, rs_cnt_d;

  logic           prot_err_q, prot_err_d;

  logic           aw_full_s, rs_full_s, wl_ready_s, bvalid_s;
  logic           aw_push_ok_s, wl_ok_s, b_pop_s, illegal_s;
  logic [AEW-1:0] aw_head_s;
  logic [REW-1:0] rs_entry_s;
  logic [REW-1:0] rs_head_s;

  // Status and handshake qualification, from registered counts only.
  always_comb begin
    aw_full_s    = (aw_cnt_q == FULL_CNT);
    rs_full_s    = (rs_cnt_q == FULL_CNT);
    wl_ready_s   = (aw_cnt_q != CNT_ZERO) && !rs_full_s;
    bvalid_s     = (rs_cnt_q != CNT_ZERO);
    aw_push_ok_s = bus.aw_push && !aw_full_s;
    wl_ok_s      = bus.wlast_push && wl_ready_s;
    b_pop_s      = bvalid_s && bus.BREADY;
    illegal_s    = (bus.aw_push && aw_full_s) || (bus.wlast_push && !wl_ready_s);
    aw_head_s    = aw_mem_q[aw_rp_q];
    rs_head_s    = rs_mem_q[rs_rp_q];
    rs_entry_s   = {aw_head_s[AEW-1 -: sID_width],
                    aw_head_s[user_width:1],
                    resp_code(aw_head_s[0], bus.w_err)};
  end

  // Next-state pointers, counts and the sticky protocol error.
  always_comb begin
    aw_wp_d    = aw_push_ok_s ? aw_wp_q + PTR_ONE : aw_wp_q;
    aw_rp_d    = wl_ok_s      ? aw_rp_q + PTR_ONE : aw_rp_q;
    rs_wp_d    = wl_ok_s      ? rs_wp_q + PTR_ONE : rs_wp_q;
    rs_rp_d    = b_pop_s      ? rs_rp_q + PTR_ONE : rs_rp_q;
    prot_err_d = prot_err_q || illegal_s;
    case ({aw_push_ok_s, wl_ok_s})
      2'b10:   aw_cnt_d = aw_cnt_q + CNT_ONE;
      2'b01:   aw_cnt_d = aw_cnt_q - CNT_ONE;
      default: aw_cnt_d = aw_cnt_q;
    endcase
    case ({wl_ok_s, b_pop_s})
      2'b10:   rs_cnt_d = rs_cnt_q + CNT_ONE;
      2'b01:   rs_cnt_d = rs_cnt_q - CNT_ONE;
      default: rs_cnt_d = rs_cnt_q;
    endcase
  end

  // Pointer, count and error registers; reset empties both queues at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_wp_q    <= '0;
      aw_rp_q    <= '0;
      aw_cnt_q   <= '0;
      rs_wp_q    <= '0;
      rs_rp_q    <= '0;
      rs_cnt_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      aw_wp_q    <= aw_wp_d;
      aw_rp_q    <= aw_rp_d;
      aw_cnt_q   <= aw_cnt_d;
      rs_wp_q    <= rs_wp_d;
      rs_rp_q    <= rs_rp_d;
      rs_cnt_q   <= rs_cnt_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Queue storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (aw_push_ok_s) begin
      aw_mem_q[aw_wp_q] <= {bus.aw_id, bus.aw_user, bus.aw_decerr};
    end
    if (wl_ok_s) begin
      rs_mem_q[rs_wp_q] <= rs_entry_s;
    end
  end

  // Payload is forced to zero while no response is pending so the bus
  // never shows stale or uninitialised storage.
  assign bus.BVALID   = bvalid_s;
  assign bus.BID      = bvalid_s ? rs_head_s[REW-1 -: sID_width] : '0;
  assign bus.BUSER    = bvalid_s ? rs_head_s[user_width+1:2]     : '0;
  assign bus.BRESP    = bvalid_s ? rs_head_s[1:0]                : 2'b00;
  assign bus.aw_full  = aw_full_s;
  assign bus.wl_ready = wl_ready_s;
  assign bus.prot_err = prot_err_q;

endmodule
